// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage: PC, single-outstanding imem fetch,
//            IF/ID register with 1-entry skid buffer, stall and redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        ins_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_ins;
  logic [31:0] ifid_pc;
  logic        skid_valid;
  logic [31:0] skid_ins;
  logic [31:0] skid_pc;

  logic        can_load;
  logic        room;
  logic        accept;
  logic        deliver;
  logic [31:0] resp_pc;

  assign can_load = !ifid_valid || !stall_i;
  assign room     = !skid_valid && can_load;
  assign accept   = (state == S_REQ) && imem_ready_i;
  assign deliver  = (state == S_WAIT) && imem_rvalid_i;
  // pc was bumped on acceptance and cannot move again until the word returns.
  assign resp_pc  = pc - 32'd4;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (imem_ready_i) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) state_nxt = (skid_valid || !can_load) ? S_HOLD : S_REQ;
      S_HOLD:  if (room) state_nxt = S_REQ;
      S_DROP:  if (imem_rvalid_i) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    // A request accepted on the redirect edge still owes a response, so it must be dropped too.
    if (redirect_i) begin
      if ((state == S_WAIT || state == S_DROP) && !imem_rvalid_i) state_nxt = S_DROP;
      else if (accept)                                             state_nxt = S_DROP;
      else                                                         state_nxt = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_ins   <= NOP_INS;
      ifid_pc    <= 32'd0;
      skid_valid <= 1'b0;
      skid_ins   <= NOP_INS;
      skid_pc    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (redirect_i) begin
        pc         <= {redirect_pc_i[31:2], 2'b00};
        ifid_valid <= 1'b0;
        ifid_ins   <= NOP_INS;
        skid_valid <= 1'b0;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (can_load) begin
          if (skid_valid) begin
            ifid_valid <= 1'b1;
            ifid_ins   <= skid_ins;
            ifid_pc    <= skid_pc;
            skid_valid <= deliver;
            if (deliver) begin
              skid_ins <= imem_rdata_i;
              skid_pc  <= resp_pc;
            end
          end else if (deliver) begin
            ifid_valid <= 1'b1;
            ifid_ins   <= imem_rdata_i;
            ifid_pc    <= resp_pc;
          end else begin
            ifid_valid <= 1'b0;
            ifid_ins   <= NOP_INS;
          end
        end else if (deliver) begin
          skid_valid <= 1'b1;
          skid_ins   <= imem_rdata_i;
          skid_pc    <= resp_pc;
        end
      end
    end
  end

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = pc;
  assign ins_o       = ifid_ins;
  assign pc_o        = ifid_pc;
  assign ins_valid_o = ifid_valid;

endmodule

`default_nettype wire
